// File: rtl/rv_pkg.sv
// Shared integer-core definitions: register file geometry and index type.
package rv_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef logic [AW-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/reg_file_if.sv
// Decode/writeback-side bundle of the integer register file: operand reads,
// writeback strobe, multi-cycle issue notification and the hazard outputs.
interface reg_file_if
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int AW   = rv_pkg::AW
);

  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            stall;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            issue_en;
  logic [AW-1:0]   issue_rd;

  modport master (
    output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, stall
  );

  modport slave (
    input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, issue_en, issue_rd,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, stall
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register (x0 excluded),
// set on multi-cycle issue, cleared by writeback, looked up for both sources.
module reg_scoreboard
  import rv_pkg::*;
#(
  parameter int NREG = rv_pkg::NREG,
  parameter int AW   = rv_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_en,
  input  logic [AW-1:0] issue_rd,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic          rs1_busy,
  output logic          rs2_busy
);

  logic [NREG-1:1] pending_q;
  logic [NREG-1:0] pending_vec;

  // A fresh issue wins over a same-cycle writeback: the new producer owns r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (issue_en && issue_rd == AW'(r)) begin
          pending_q[r] <= 1'b1;
        end else if (wr_en && wr_addr == AW'(r)) begin
          pending_q[r] <= 1'b0;
        end
      end
    end
  end

  assign pending_vec = {pending_q, 1'b0};

  // The clearing writeback is bypassed this cycle, so it releases the stall now.
  always_comb begin
    rs1_busy = pending_vec[rs1_addr] && !(wr_en && wr_addr == rs1_addr);
    rs2_busy = pending_vec[rs2_addr] && !(wr_en && wr_addr == rs2_addr);
  end

endmodule

// File: rtl/reg_file.sv
// Integer register file feeding the ALU: 2 combinational read ports with
// write bypass, one write port, x0 hard-wired to zero, pending-write scoreboard.
module reg_file
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int NREG = rv_pkg::NREG,
  parameter int AW   = rv_pkg::AW
) (
  input logic       clk,
  input logic       rst_n,
  reg_file_if.slave bus
);

  logic [XLEN-1:0] regs [1:NREG-1];
  logic            rs1_busy;
  logic            rs2_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wr_en && bus.wr_addr != ZERO_REG) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // x0 check comes first so a discarded x0 write is never bypassed.
  always_comb begin
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    if (bus.rs1_addr != ZERO_REG) begin
      if (bus.wr_en && bus.wr_addr == bus.rs1_addr) begin
        bus.rs1_data = bus.wr_data;
      end else begin
        bus.rs1_data = regs[bus.rs1_addr];
      end
    end
    if (bus.rs2_addr != ZERO_REG) begin
      if (bus.wr_en && bus.wr_addr == bus.rs2_addr) begin
        bus.rs2_data = bus.wr_data;
      end else begin
        bus.rs2_data = regs[bus.rs2_addr];
      end
    end
  end

  reg_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue_en (bus.issue_en),
    .issue_rd (bus.issue_rd),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rs1_addr (bus.rs1_addr),
    .rs2_addr (bus.rs2_addr),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

  assign bus.rs1_busy = rs1_busy;
  assign bus.rs2_busy = rs2_busy;
  assign bus.stall    = rs1_busy | rs2_busy;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, bypass, x0, scoreboard
// issue/writeback ordering and asynchronous reset.
module tb_reg_file;
  import rv_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  reg_file_if bus ();

  reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge; outputs settle and are checked at +3.
  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                               input logic ie, input logic [4:0] ird,
                               input logic [4:0] r1, input logic [4:0] r2);
    bus.wr_en    = we;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.issue_en = ie;
    bus.issue_rd = ird;
    bus.rs1_addr = r1;
    bus.rs2_addr = r2;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, actual, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset state across every address on both ports
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'(i), 5'(31 - i));
      checkOutput("reset_rs1", bus.rs1_data, 64'h0);
      checkOutput("reset_rs2", bus.rs2_data, 64'h0);
      checkOutput("reset_stall", {63'h0, bus.stall}, 64'h0);
    end
    tick();

    // Write x5 with same-cycle read
    applyStimulus(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 1'b0, 5'd0, 5'd5, 5'd0);
    checkOutput("x5_bypass", bus.rs1_data, 64'hDEAD_BEEF_0000_0001);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    checkOutput("x5_stored_rs1", bus.rs1_data, 64'hDEAD_BEEF_0000_0001);
    checkOutput("x5_stored_rs2", bus.rs2_data, 64'hDEAD_BEEF_0000_0001);
    checkOutput("x5_not_busy", {63'h0, bus.rs1_busy}, 64'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd5, 5'd6);
    checkOutput("x5_later", bus.rs1_data, 64'hDEAD_BEEF_0000_0001);
    checkOutput("x6_zero", bus.rs2_data, 64'h0);
    tick();

    // x0 write discarded and never bypassed; issue to x0 ignored
    applyStimulus(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_no_bypass", bus.rs2_data, 64'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_after_write", bus.rs2_data, 64'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_issue_busy", {63'h0, bus.rs2_busy}, 64'h0);
    checkOutput("x0_issue_stall", {63'h0, bus.stall}, 64'h0);
    tick();

    // Issue x7; busy from next cycle until writeback cycle
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 5'd7, 5'd0);
    checkOutput("x7_issue_cycle_busy", {63'h0, bus.rs1_busy}, 64'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    checkOutput("x7_busy", {63'h0, bus.rs1_busy}, 64'h1);
    checkOutput("x7_stall", {63'h0, bus.stall}, 64'h1);
    checkOutput("x7_rs2_free", {63'h0, bus.rs2_busy}, 64'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    checkOutput("x7_still_busy", {63'h0, bus.rs1_busy}, 64'h1);
    tick();
    applyStimulus(1'b1, 5'd7, 64'h42, 1'b0, 5'd0, 5'd7, 5'd0);
    checkOutput("x7_wb_busy", {63'h0, bus.rs1_busy}, 64'h0);
    checkOutput("x7_wb_stall", {63'h0, bus.stall}, 64'h0);
    checkOutput("x7_wb_data", bus.rs1_data, 64'h42);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    checkOutput("x7_after_busy", {63'h0, bus.rs1_busy}, 64'h0);
    checkOutput("x7_after_data", bus.rs1_data, 64'h42);
    tick();

    // Simultaneous issue and writeback to x9: issue wins
    applyStimulus(1'b1, 5'd9, 64'h11, 1'b1, 5'd9, 5'd0, 5'd9);
    checkOutput("x9_same_busy", {63'h0, bus.rs2_busy}, 64'h0);
    checkOutput("x9_same_data", bus.rs2_data, 64'h11);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd9);
    checkOutput("x9_next_busy", {63'h0, bus.rs2_busy}, 64'h1);
    checkOutput("x9_next_stall", {63'h0, bus.stall}, 64'h1);
    checkOutput("x9_next_data", bus.rs2_data, 64'h11);
    tick();
    applyStimulus(1'b1, 5'd9, 64'h22, 1'b0, 5'd0, 5'd0, 5'd9);
    checkOutput("x9_wb_busy", {63'h0, bus.rs2_busy}, 64'h0);
    checkOutput("x9_wb_data", bus.rs2_data, 64'h22);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    checkOutput("x9_final_busy", {63'h0, bus.rs1_busy}, 64'h0);
    checkOutput("x9_final_data", bus.rs1_data, 64'h22);
    tick();

    // Double issue to x12: one writeback clears it
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd12, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd12, 5'd12, 5'd0);
    checkOutput("x12_pending", {63'h0, bus.rs1_busy}, 64'h1);
    tick();
    applyStimulus(1'b1, 5'd12, 64'h5A, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd12, 5'd12);
    checkOutput("x12_cleared", {63'h0, bus.stall}, 64'h0);
    checkOutput("x12_data", bus.rs2_data, 64'h5A);
    tick();

    // Asynchronous reset mid-cycle
    applyStimulus(1'b1, 5'd3, 64'h123, 1'b1, 5'd4, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd3, 5'd4);
    checkOutput("pre_reset_x3", bus.rs1_data, 64'h123);
    checkOutput("pre_reset_x4_busy", {63'h0, bus.rs2_busy}, 64'h1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_x3", bus.rs1_data, 64'h0);
    checkOutput("async_reset_x4_busy", {63'h0, bus.rs2_busy}, 64'h0);
    checkOutput("async_reset_stall", {63'h0, bus.stall}, 64'h0);
    checkOutput("async_reset_x7", (bus.rs1_addr == 5'd3) ? bus.rs1_data : 64'hX, 64'h0);
    applyStimulus(1'b1, 5'd3, 64'h77, 1'b0, 5'd0, 5'd3, 5'd7);
    checkOutput("reset_bypass", bus.rs1_data, 64'h77);
    checkOutput("reset_x7_lost", bus.rs2_data, 64'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd3, 5'd0);
    checkOutput("reset_held_no_write", bus.rs1_data, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
